axi4_mmio_router: RTL and testbench

Synthesizable AXI4-lite address router placed between `picorv32_axi` (slave side, `s_axi_*`) and the main AXI4-lite memory (master side, `m_axi_*`). Forwards RAM-range transactions to memory and terminates two MMIO locations locally: a console byte port backed by a FIFO, and a test-status register. Any other address completes locally with a sticky bus-error flag, so a stray access never hangs the core. Each direction supports one outstanding transaction.

---
 rtl/axi4_mmio_router_if.sv | 35 +++
 rtl/axi4_mmio_router.sv | 236 +++++++++++++++++++++++
 tb/tb_axi4_mmio_router.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_mmio_router_if.sv
// AXI4-lite channel bundle (no resp fields) shared by the core-facing and
// memory-facing sides of axi4_mmio_router.
//   master modport: drives AW/W/AR valid+payload and B/R ready.
//   slave  modport: drives AW/W/AR ready and B/R valid + read data.
interface axi4_mmio_router_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );
endinterface

// File: rtl/axi4_mmio_router.sv
// AXI4-lite address router between the CPU core and main memory.
// RAM-range accesses are forwarded to memory; the console byte port and the
// test-status register are terminated locally; anything else completes
// locally with a sticky bus-error flag. One outstanding transaction per
// direction; read and write paths are independent.
// Ports:
//   clk, resetn      - clock, synchronous active-low reset
//   s_axi (slave)    - AXI4-lite from the core
//   m_axi (master)   - AXI4-lite toward memory
//   console_valid/ready/data - console byte stream (FIFO head)
//   tests_passed     - sticky pass flag
//   bus_error        - sticky decode-error flag
//   error_addr       - address of the first decode error
module axi4_mmio_router #(
  parameter int          MEM_BYTES    = 131072,
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter logic [31:0] STATUS_ADDR  = 32'h2000_0000,
  parameter int          PASS_MAGIC   = 123456789,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic                clk,
  input  logic                resetn,
  axi4_mmio_router_if.slave   s_axi,
  axi4_mmio_router_if.master  m_axi,
  output logic                console_valid,
  input  logic                console_ready,
  output logic [7:0]          console_data,
  output logic                tests_passed,
  output logic                bus_error,
  output logic [31:0]         error_addr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [2:0] {W_IDLE, W_DEC, W_FWD, W_BWAIT, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_WAIT, R_RESP} rstate_t;
  typedef enum logic [1:0] {D_MEM, D_CON, D_STS, D_ERR} dec_t;

  function automatic dec_t decode(input logic [31:0] a);
    if (a < 32'(MEM_BYTES))    return D_MEM;
    else if (a == CONSOLE_ADDR) return D_CON;
    else if (a == STATUS_ADDR)  return D_STS;
    else                        return D_ERR;
  endfunction

  wstate_t     w_state_q, w_state_d;
  rstate_t     r_state_q, r_state_d;
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic        m_aw_done_q, m_aw_done_d, m_w_done_q, m_w_done_d;
  logic        rdy_en_q;
  logic        tests_passed_q, tests_passed_d, bus_error_q, bus_error_d;
  logic [31:0] error_addr_q, error_addr_d;
  logic [31:0] awaddr_q, wdata_q, araddr_q, rdata_q, rdata_d;
  logic [2:0]  awprot_q, arprot_q;
  logic [3:0]  wstrb_q;
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fifo_count;

  logic aw_hs, w_hs, ar_hs, m_aw_hs, m_w_hs;
  logic fifo_full, fifo_empty, push, pop, w_err, r_err;
  dec_t w_dec, ar_dec;

  assign aw_hs   = s_axi.awvalid && s_axi.awready;
  assign w_hs    = s_axi.wvalid  && s_axi.wready;
  assign ar_hs   = s_axi.arvalid && s_axi.arready;
  assign m_aw_hs = m_axi.awvalid && m_axi.awready;
  assign m_w_hs  = m_axi.wvalid  && m_axi.wready;
  assign w_dec   = decode(awaddr_q);
  assign ar_dec  = decode(s_axi.araddr);

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign push = (w_state_q == W_DEC) && (w_dec == D_CON) && wstrb_q[0] && !fifo_full;
  assign pop  = console_valid && console_ready;
  assign w_err = (w_state_q == W_DEC) && (w_dec == D_ERR);
  assign r_err = ar_hs && (ar_dec == D_ERR);

  // State registers (control only is reset)
  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state_q      <= W_IDLE;
      r_state_q      <= R_IDLE;
      aw_held_q      <= 1'b0;
      w_held_q       <= 1'b0;
      m_aw_done_q    <= 1'b0;
      m_w_done_q     <= 1'b0;
      rdy_en_q       <= 1'b0;
      tests_passed_q <= 1'b0;
      bus_error_q    <= 1'b0;
      error_addr_q   <= 32'h0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
    end else begin
      w_state_q      <= w_state_d;
      r_state_q      <= r_state_d;
      aw_held_q      <= aw_held_d;
      w_held_q       <= w_held_d;
      m_aw_done_q    <= m_aw_done_d;
      m_w_done_q     <= m_w_done_d;
      rdy_en_q       <= 1'b1;
      tests_passed_q <= tests_passed_d;
      bus_error_q    <= bus_error_d;
      error_addr_q   <= error_addr_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
    end
  end

  // Payload registers
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      awaddr_q <= s_axi.awaddr;
      awprot_q <= s_axi.awprot;
    end
    if (w_hs) begin
      wdata_q <= s_axi.wdata;
      wstrb_q <= s_axi.wstrb;
    end
    if (ar_hs) begin
      araddr_q <= s_axi.araddr;
      arprot_q <= s_axi.arprot;
    end
    rdata_q <= rdata_d;
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= wdata_q[7:0];
  end

  // Write FSM next state
  always_comb begin
    w_state_d   = w_state_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    m_aw_done_d = m_aw_done_q;
    m_w_done_d  = m_w_done_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) aw_held_d = 1'b1;
        if (w_hs)  w_held_d  = 1'b1;
        if (aw_held_d && w_held_d) w_state_d = W_DEC;
      end
      W_DEC: begin
        m_aw_done_d = 1'b0;
        m_w_done_d  = 1'b0;
        case (w_dec)
          D_MEM:   w_state_d = W_FWD;
          D_CON:   if (!(wstrb_q[0] && fifo_full)) w_state_d = W_RESP;
          default: w_state_d = W_RESP;
        endcase
      end
      W_FWD: begin
        if (m_aw_hs) m_aw_done_d = 1'b1;
        if (m_w_hs)  m_w_done_d  = 1'b1;
        if (m_aw_done_d && m_w_done_d) w_state_d = W_BWAIT;
      end
      W_BWAIT: if (m_axi.bvalid) w_state_d = W_RESP;
      W_RESP: begin
        if (s_axi.bready) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM next state; local responses are loaded at AR decode
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_RESP;
          case (ar_dec)
            D_MEM:   r_state_d = R_FWD;
            D_CON:   rdata_d = {{(32-PW){1'b0}}, fifo_count};
            D_STS:   rdata_d = {31'b0, tests_passed_q};
            default: rdata_d = 32'hDEAD_BEEF;
          endcase
        end
      end
      R_FWD: if (m_axi.arready) r_state_d = R_WAIT;
      R_WAIT: begin
        if (m_axi.rvalid) begin
          rdata_d   = m_axi.rdata;
          r_state_d = R_RESP;
        end
      end
      R_RESP: if (s_axi.rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Sticky flags and FIFO pointers; a write error wins the error_addr slot
  always_comb begin
    tests_passed_d = tests_passed_q |
                     ((w_state_q == W_DEC) && (w_dec == D_STS) && (wdata_q == 32'(PASS_MAGIC)));
    bus_error_d  = bus_error_q | w_err | r_err;
    error_addr_d = error_addr_q;
    if (!bus_error_q) begin
      if (w_err)      error_addr_d = awaddr_q;
      else if (r_err) error_addr_d = s_axi.araddr;
    end
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end

  // Outputs (all decoded from registers only)
  always_comb begin
    s_axi.awready = (w_state_q == W_IDLE) && !aw_held_q && rdy_en_q;
    s_axi.wready  = (w_state_q == W_IDLE) && !w_held_q && rdy_en_q;
    s_axi.bvalid  = (w_state_q == W_RESP);
    m_axi.awvalid = (w_state_q == W_FWD) && !m_aw_done_q;
    m_axi.awaddr  = awaddr_q;
    m_axi.awprot  = awprot_q;
    m_axi.wvalid  = (w_state_q == W_FWD) && !m_w_done_q;
    m_axi.wdata   = wdata_q;
    m_axi.wstrb   = wstrb_q;
    m_axi.bready  = (w_state_q == W_BWAIT);
    s_axi.arready = (r_state_q == R_IDLE) && rdy_en_q;
    s_axi.rvalid  = (r_state_q == R_RESP);
    s_axi.rdata   = rdata_q;
    m_axi.arvalid = (r_state_q == R_FWD);
    m_axi.araddr  = araddr_q;
    m_axi.arprot  = arprot_q;
    m_axi.rready  = (r_state_q == R_WAIT);
    console_valid = !fifo_empty;
    console_data  = fifo_mem[rd_ptr_q[AW-1:0]];
    tests_passed  = tests_passed_q;
    bus_error     = bus_error_q;
    error_addr    = error_addr_q;
  end
endmodule

// File: tb/tb_axi4_mmio_router.sv
module tb_axi4_mmio_router;
  localparam int B_LAT = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  axi4_mmio_router_if s_if ();
  axi4_mmio_router_if m_if ();
  logic        console_valid, console_ready, tests_passed, bus_error;
  logic [7:0]  console_data;
  logic [31:0] error_addr;

  axi4_mmio_router dut (
    .clk(clk), .resetn(resetn), .s_axi(s_if.slave), .m_axi(m_if.master),
    .console_valid(console_valid), .console_ready(console_ready),
    .console_data(console_data), .tests_passed(tests_passed),
    .bus_error(bus_error), .error_addr(error_addr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Console monitor: counts valid cycles and logs popped bytes
  int         con_cycles = 0;
  logic [7:0] con_q [$];
  initial forever begin
    @(negedge clk); #1;
    if (console_valid) begin
      con_cycles++;
      if (console_ready) con_q.push_back(console_data);
    end
  end

  // Memory model: always-ready address/data, B after B_LAT cycles, R next cycle
  logic [31:0] mem [0:255];
  logic        aw_f, w_f, b_f, ar_f, r_f, rst_seen, got_aw, got_w;
  logic [31:0] aw_a, w_d, ar_a, pw_a, pw_d;
  logic [3:0]  w_s, pw_s;
  int          b_cnt;
  initial begin
    m_if.awready = 1; m_if.wready = 1; m_if.arready = 1;
    m_if.bvalid = 0; m_if.rvalid = 0; m_if.rdata = 0;
    got_aw = 0; got_w = 0; b_cnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    forever begin
      @(negedge clk); #1;
      rst_seen = !resetn;
      aw_f = m_if.awvalid && m_if.awready; aw_a = m_if.awaddr;
      w_f  = m_if.wvalid && m_if.wready;   w_d = m_if.wdata; w_s = m_if.wstrb;
      b_f  = m_if.bvalid && m_if.bready;
      ar_f = m_if.arvalid && m_if.arready; ar_a = m_if.araddr;
      r_f  = m_if.rvalid && m_if.rready;
      @(posedge clk); #1;
      if (rst_seen) begin
        got_aw = 0; got_w = 0; b_cnt = 0; m_if.bvalid = 0; m_if.rvalid = 0;
      end else begin
        if (b_f) m_if.bvalid = 0;
        if (r_f) m_if.rvalid = 0;
        if (b_cnt > 0) begin
          b_cnt--;
          if (b_cnt == 0) begin
            for (int b = 0; b < 4; b++)
              if (pw_s[b]) mem[pw_a[9:2]][8*b +: 8] = pw_d[8*b +: 8];
            m_if.bvalid = 1;
          end
        end
        if (aw_f) begin got_aw = 1; pw_a = aw_a; end
        if (w_f)  begin got_w = 1; pw_d = w_d; pw_s = w_s; end
        if (got_aw && got_w) begin got_aw = 0; got_w = 0; b_cnt = B_LAT; end
        if (ar_f) begin m_if.rdata = mem[ar_a[9:2]]; m_if.rvalid = 1; end
      end
    end
  end

  // Core-side drivers (called at a negedge, return at a negedge)
  task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] st, input int w_lead, output bit ok);
    bit awp, wp, af, wf;
    int c;
    awp = 1; wp = 1; c = 0;
    s_if.awaddr = a; s_if.awprot = 3'b000; s_if.wdata = d; s_if.wstrb = st;
    s_if.wvalid = 1; s_if.awvalid = (w_lead == 0);
    while ((awp || wp) && c < 100) begin
      af = s_if.awvalid && s_if.awready;
      wf = s_if.wvalid && s_if.wready;
      @(negedge clk); c++;
      if (af) begin s_if.awvalid = 0; awp = 0; end
      if (wf) begin s_if.wvalid = 0; wp = 0; end
      if (awp && !s_if.awvalid && c >= w_lead) s_if.awvalid = 1;
    end
    s_if.awvalid = 0; s_if.wvalid = 0;
    ok = !(awp || wp);
  endtask

  task automatic wait_b(input int max_cyc, output bit got, output int lat);
    got = 0; lat = 0; s_if.bready = 1;
    while (!got && lat < max_cyc) begin
      if (s_if.bvalid) got = 1;
      else begin @(negedge clk); lat++; end
    end
    if (got) @(negedge clk);
    s_if.bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] data,
                          output bit ok, output int lat);
    int c;
    c = 0;
    s_if.araddr = a; s_if.arprot = 3'b000; s_if.arvalid = 1; s_if.rready = 0;
    while (!s_if.arready && c < 100) begin @(negedge clk); c++; end
    @(negedge clk);
    s_if.arvalid = 0; s_if.rready = 1; lat = 0;
    while (!s_if.rvalid && lat < 100) begin @(negedge clk); lat++; end
    ok = s_if.rvalid; data = s_if.rdata;
    @(negedge clk);
    s_if.rready = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({s_if.awready, s_if.wready, s_if.arready, s_if.bvalid, s_if.rvalid,
         m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready,
         console_valid, tests_passed, bus_error} !== 13'b0) begin
      n_fail++; $display("FAIL reset_outputs: some valid/ready/flag is 1, required all 0");
    end
    n_checks++;
    if (error_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_error_addr: got %h required 00000000", error_addr);
    end
    resetn = 1;
    @(negedge clk);
    n_checks++;
    if ({s_if.awready, s_if.wready, s_if.arready} !== 3'b111) begin
      n_fail++; $display("FAIL ready_after_reset: got %b required 111",
                         {s_if.awready, s_if.wready, s_if.arready});
    end
  endtask

  task automatic test_mem_rw();
    bit ok, got; int lat; logic [31:0] d;
    send_aw_w(32'h0000_0100, 32'hCAFE_F00D, 4'b1111, 0, ok);
    wait_b(40, got, lat);
    n_checks++;
    if (!(ok && got)) begin n_fail++; $display("FAIL mem_write_done: got %b required 1", ok && got); end
    n_checks++;
    if (mem[8'h40] !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL mem_word: got %h required cafef00d", mem[8'h40]);
    end
    axi_read(32'h0000_0100, d, ok, lat);
    n_checks++;
    if (!ok || d !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL mem_read: got %h ok=%b required cafef00d", d, ok);
    end
    n_checks++;
    if ({tests_passed, bus_error} !== 2'b00) begin
      n_fail++; $display("FAIL mem_flags: got %b required 00", {tests_passed, bus_error});
    end
  endtask

  task automatic test_console();
    bit ok, got; int lat;
    con_q.delete(); con_cycles = 0; console_ready = 1;
    send_aw_w(32'h1000_0000, 32'h0000_0048, 4'b0001, 0, ok);
    wait_b(20, got, lat);
    n_checks++;
    if (!(ok && got) || lat != 1) begin
      n_fail++; $display("FAIL console_write_latency: got lat=%0d done=%b required lat=1 done=1", lat, ok && got);
    end
    send_aw_w(32'h1000_0000, 32'h0000_0069, 4'b0001, 0, ok);
    wait_b(20, got, lat);
    repeat (4) @(negedge clk);
    n_checks++;
    if (con_q.size() != 2 || con_q[0] !== 8'h48 || con_q[1] !== 8'h69) begin
      n_fail++; $display("FAIL console_bytes: got %0d bytes required 48 69", con_q.size());
    end
    n_checks++;
    if (con_cycles != 2) begin
      n_fail++; $display("FAIL console_valid_cycles: got %0d required 2", con_cycles);
    end
  endtask

  task automatic test_fifo_full();
    bit ok, got, all_ok, seq_ok; int lat; logic [31:0] d;
    console_ready = 0; con_q.delete(); all_ok = 1;
    for (int i = 0; i < 8; i++) begin
      send_aw_w(32'h1000_0000, 32'h30 + i, 4'b0001, 0, ok);
      wait_b(20, got, lat);
      if (!(ok && got)) all_ok = 0;
    end
    n_checks++;
    if (!all_ok) begin n_fail++; $display("FAIL fifo_fill: got incomplete write, required 8 completions"); end
    send_aw_w(32'h1000_0000, 32'h38, 4'b0001, 0, ok);
    wait_b(10, got, lat);
    n_checks++;
    if (got) begin n_fail++; $display("FAIL fifo_full_stall: got bvalid=1 required withheld"); end
    axi_read(32'h1000_0000, d, ok, lat);
    n_checks++;
    if (!ok || d !== 32'd8 || lat != 0) begin
      n_fail++; $display("FAIL fifo_count_read: got %h lat=%0d required 00000008 lat=0", d, lat);
    end
    console_ready = 1;
    wait_b(20, got, lat);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL fifo_release: got bvalid=0 required 1"); end
    repeat (12) @(negedge clk);
    seq_ok = (con_q.size() == 9);
    for (int i = 0; i < con_q.size() && i < 9; i++)
      if (con_q[i] !== 8'(8'h30 + i)) seq_ok = 0;
    n_checks++;
    if (!seq_ok || console_valid !== 1'b0) begin
      n_fail++; $display("FAIL fifo_drain: got %0d bytes valid=%b required 30..38 and empty",
                         con_q.size(), console_valid);
    end
  endtask

  task automatic test_status();
    bit ok, got; int lat; logic [31:0] d;
    send_aw_w(32'h2000_0000, 32'd123456788, 4'b1111, 0, ok);
    wait_b(20, got, lat);
    n_checks++;
    if (tests_passed !== 1'b0) begin n_fail++; $display("FAIL status_near_magic: got %b required 0", tests_passed); end
    send_aw_w(32'h2000_0000, 32'd123456789, 4'b1111, 0, ok);
    wait_b(20, got, lat);
    n_checks++;
    if (tests_passed !== 1'b1) begin n_fail++; $display("FAIL status_magic: got %b required 1", tests_passed); end
    send_aw_w(32'h2000_0000, 32'd0, 4'b1111, 0, ok);
    wait_b(20, got, lat);
    n_checks++;
    if (tests_passed !== 1'b1 || !got) begin
      n_fail++; $display("FAIL status_sticky: got %b required 1", tests_passed);
    end
    axi_read(32'h2000_0000, d, ok, lat);
    n_checks++;
    if (!ok || d !== 32'd1) begin n_fail++; $display("FAIL status_read: got %h required 00000001", d); end
  endtask

  task automatic test_decode_error();
    bit ok, got; int lat; logic [31:0] d;
    axi_read(32'h3000_0000, d, ok, lat);
    n_checks++;
    if (!ok || d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL err_read_data: got %h required deadbeef", d); end
    n_checks++;
    if (bus_error !== 1'b1 || error_addr !== 32'h3000_0000) begin
      n_fail++; $display("FAIL err_read_flag: got %b/%h required 1/30000000", bus_error, error_addr);
    end
    send_aw_w(32'h0002_0000, 32'h0000_1234, 4'b1111, 0, ok);
    wait_b(20, got, lat);
    n_checks++;
    if (!(ok && got) || bus_error !== 1'b1 || error_addr !== 32'h3000_0000) begin
      n_fail++; $display("FAIL err_write: got done=%b %b/%h required 1 1/30000000", ok && got, bus_error, error_addr);
    end
    n_checks++;
    if (mem[0] !== 32'h0) begin n_fail++; $display("FAIL err_write_leak: got mem[0]=%h required 0", mem[0]); end
  endtask

  task automatic test_reset_mid_write();
    bit ok, got, seen_b, in_bwait; int lat, c; logic [31:0] d;
    send_aw_w(32'h0000_0200, 32'h0000_55AA, 4'b1111, 3, ok);
    c = 0; in_bwait = 0;
    while (!in_bwait && c < 20) begin
      if (m_if.bready) in_bwait = 1; else begin @(negedge clk); c++; end
    end
    n_checks++;
    if (!(ok && in_bwait)) begin n_fail++; $display("FAIL reach_bwait: got %b required 1", ok && in_bwait); end
    s_if.bready = 1; seen_b = 0;
    resetn = 0;
    repeat (2) begin @(negedge clk); if (s_if.bvalid) seen_b = 1; end
    n_checks++;
    if ({s_if.awready, s_if.wready, s_if.arready, s_if.bvalid, s_if.rvalid,
         m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready,
         console_valid, tests_passed, bus_error} !== 13'b0 || error_addr !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got flags %b/%b addr %h required all 0",
                         tests_passed, bus_error, error_addr);
    end
    resetn = 1;
    repeat (6) begin @(negedge clk); if (s_if.bvalid) seen_b = 1; end
    s_if.bready = 0;
    n_checks++;
    if (seen_b) begin n_fail++; $display("FAIL abandoned_bvalid: got bvalid=1 required 0"); end
    n_checks++;
    if ({s_if.awready, s_if.wready, s_if.arready} !== 3'b111) begin
      n_fail++; $display("FAIL ready_after_mid_reset: got %b required 111",
                         {s_if.awready, s_if.wready, s_if.arready});
    end
    send_aw_w(32'h0000_0204, 32'h1234_5678, 4'b1111, 0, ok);
    wait_b(40, got, lat);
    axi_read(32'h0000_0204, d, ok, lat);
    n_checks++;
    if (!(got && ok) || d !== 32'h1234_5678) begin
      n_fail++; $display("FAIL fresh_write_after_reset: got %h required 12345678", d);
    end
  endtask

  initial begin
    resetn = 0; console_ready = 0;
    s_if.awvalid = 0; s_if.awaddr = 0; s_if.awprot = 0;
    s_if.wvalid = 0; s_if.wdata = 0; s_if.wstrb = 0; s_if.bready = 0;
    s_if.arvalid = 0; s_if.araddr = 0; s_if.arprot = 0; s_if.rready = 0;
    @(negedge clk);
    test_reset();
    test_mem_rw();
    test_console();
    test_fifo_full();
    test_status();
    test_decode_error();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
